// File: rtl/bram_stream_loader.sv
// -----------------------------------------------------------------------------
// bram_stream_loader
//
// Write-side feeder for one accelerator input BRAM. It takes a valid/ready word
// stream from the host/DMA side and turns each accepted word into one BRAM
// write. When the programmed number of words has been stored, or the stream
// ends early with s_last, it raises load_done, which releases the scheduler.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   start           : 1-cycle pulse that arms a load (honoured in IDLE/DONE only)
//   num_words       : words to load, sampled on start
//   s_data/s_valid/s_ready/s_last : input word stream
//   bram_din/bram_ena/bram_addra  : BRAM write port (registered)
//   load_done       : level, load complete and BRAM contents valid
//   busy            : high while in LOAD
//   err_len         : sticky length error (early/missing s_last, num_words > DEPTH)
//   words_written   : words written in the current/last load
//   dbg_state       : current FSM state (0=IDLE, 1=LOAD, 2=DONE)
//
// Handshake: a word transfers on a rising clk edge when s_valid && s_ready.
// s_ready depends only on the FSM state, never on s_valid. The producer may
// assert s_valid at any time; words presented outside LOAD are ignored.
// -----------------------------------------------------------------------------
module bram_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 242101,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_ena,
  output logic [ADDR_W-1:0]     bram_addra,
  output logic                  load_done,
  output logic                  busy,
  output logic                  err_len,
  output logic [CNT_W-1:0]      words_written,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e                  state_q;
  logic [CNT_W-1:0]        target_q;
  logic [CNT_W-1:0]        ww_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic                    ena_q;
  logic [ADDR_W-1:0]       addra_q;
  logic                    load_done_q;
  logic                    err_len_q;

  logic hs;
  logic count_final;

  assign hs = s_valid && (state_q == S_LOAD);
  // This word is the last one the programmed count allows. target_q is clamped
  // to DEPTH, so ww_q stays below DEPTH and doubles as the write address.
  assign count_final = ((ww_q + ONE_C) == target_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      ww_q        <= '0;
      din_q       <= '0;
      ena_q       <= 1'b0;
      addra_q     <= '0;
      load_done_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      ena_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            target_q    <= (num_words > DEPTH_C) ? DEPTH_C : num_words;
            err_len_q   <= (num_words > DEPTH_C);
            ww_q        <= '0;
            // An empty load completes immediately without touching the BRAM.
            load_done_q <= (num_words == '0);
            state_q     <= (num_words == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (hs) begin
            ena_q   <= 1'b1;
            din_q   <= s_data;
            addra_q <= ww_q[ADDR_W-1:0];
            ww_q    <= ww_q + ONE_C;
            if (count_final || s_last) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
              // s_last and the count must agree; either one alone is an error.
              if (count_final != s_last) err_len_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready       = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD);
  assign bram_din      = din_q;
  assign bram_ena      = ena_q;
  assign bram_addra    = addra_q;
  assign load_done     = load_done_q;
  assign err_len       = err_len_q;
  assign words_written = ww_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_loader
//
// Bench for bram_stream_loader built with DEPTH=8, DATA_WIDTH=8. Each load's
// outcome (accepted words, write addresses/data, error flag) is predicted from
// the load rules with plain arithmetic before the stream is driven. Expected
// BRAM writes, tagged with the cycle they must appear in, go into exp_q and a
// negedge monitor retires them against bram_ena.
// -----------------------------------------------------------------------------
module tb_bram_stream_loader;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] ww;
    logic          done;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start     = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [DW-1:0] s_data    = '0;
  logic          s_valid   = 1'b0;
  logic          s_last    = 1'b0;
  logic          s_ready;
  logic [DW-1:0] bram_din;
  logic          bram_ena;
  logic [AW-1:0] bram_addra;
  logic          load_done;
  logic          busy;
  logic          err_len;
  logic [CW-1:0] words_written;
  logic [1:0]    dbg_state;

  bram_stream_loader #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_words    (num_words),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .bram_din     (bram_din),
    .bram_ena     (bram_ena),
    .bram_addra   (bram_addra),
    .load_done    (load_done),
    .busy         (busy),
    .err_len      (err_len),
    .words_written(words_written),
    .dbg_state    (dbg_state)
  );

  logic [31:0]      cyc_cnt = '0;
  logic [EXP_W-1:0] exp_q[$];
  logic [DW-1:0]    wdata[16];
  int               n_cmp = 0;
  int               n_err = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // write monitor: every bram_ena must match the oldest expected write, in the
  // exact cycle predicted; an expected write whose cycle passes is missing.
  always @(negedge clk) begin
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_t'(exp_q[0]);
    if (bram_ena) begin
      if (exp_q.size() == 0) begin
        check("spurious_ena", 32'(1), 32'(0));
      end else begin
        void'(exp_q.pop_front());
        check("wr_addr",  32'(bram_addra),    32'(e.addr));
        check("wr_data",  32'(bram_din),      32'(e.data));
        check("wr_count", 32'(words_written), 32'(e.ww));
        check("wr_done",  32'(load_done),     32'(e.done));
        check("wr_cycle", cyc_cnt,            e.cyc);
      end
    end else if (exp_q.size() > 0 && e.cyc <= cyc_cnt) begin
      void'(exp_q.pop_front());
      check("missing_ena", 32'(0), 32'(1));
    end
  end

  // driver tasks: inputs change 1 time unit after posedge, checks at negedge
  task automatic idle_cycle(input bit poke);
    @(posedge clk); #1;
    start     = poke;
    num_words = CW'($urandom_range(0, 15));
    s_valid   = 1'b0;
    s_data    = DW'($urandom_range(0, 255));
    s_last    = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input bit lst, input int k, input bit fin);
    exp_t e;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = lst;
    @(negedge clk);
    check("s_ready", 32'(s_ready), 32'(1));
    if (s_ready) begin
      e.cyc  = cyc_cnt + 32'd1;
      e.addr = AW'(k);
      e.data = d;
      e.ww   = CW'(k + 1);
      e.done = fin;
      exp_q.push_back(EXP_W'(e));
    end
  endtask

  // One complete load. The reference outcome: target = min(n, DEPTH); words
  // are accepted in order until the count reaches target or s_last is seen;
  // an error is flagged for n > DEPTH or when the two end conditions disagree.
  task automatic run_load(input int n, input int last_pos, input int gap_fixed, input bit poke);
    int target, a, g;
    bit by_last, exp_err;
    target  = (n > DEPTH) ? DEPTH : n;
    a       = 0;
    by_last = 1'b0;
    if (target > 0) begin
      for (int k = 0; k < 16; k++) begin
        a = k + 1;
        if (k == last_pos) begin
          by_last = 1'b1;
          break;
        end
        if (a == target) break;
      end
    end
    exp_err = (n > DEPTH) || ((a > 0) && (by_last != (a == target)));

    @(posedge clk); #1;
    start     = 1'b1;
    num_words = CW'(n);
    s_valid   = 1'b0;
    s_last    = 1'b0;
    @(posedge clk); #1;
    start     = 1'b0;
    num_words = CW'($urandom_range(0, 15));
    @(negedge clk);
    check("start_err",  32'(err_len),       32'(n > DEPTH));
    check("start_done", 32'(load_done),     32'(n == 0));
    check("start_busy", 32'(busy),          32'(n != 0));
    check("start_cnt",  32'(words_written), 32'(0));

    for (int k = 0; k < a; k++) begin
      g = (gap_fixed >= 0) ? ((k == 0) ? 0 : gap_fixed) : $urandom_range(0, 2);
      repeat (g) idle_cycle(poke && ($urandom_range(0, 3) == 0));
      drive_word(wdata[k], (k == last_pos), k, (k == a - 1));
    end

    // a stray word after the load must be ignored
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = DW'($urandom_range(0, 255));
    s_last  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("end_ready", 32'(s_ready),   32'(0));
    check("end_done",  32'(load_done), 32'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    check("end_err",     32'(err_len),       32'(exp_err));
    check("end_cnt",     32'(words_written), 32'(a));
    check("end_busy",    32'(busy),          32'(0));
    check("end_pending", 32'(exp_q.size()),  32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"},   32'(bram_ena),      32'(0));
    check({tag, "_din"},   32'(bram_din),      32'(0));
    check({tag, "_addr"},  32'(bram_addra),    32'(0));
    check({tag, "_done"},  32'(load_done),     32'(0));
    check({tag, "_busy"},  32'(busy),          32'(0));
    check({tag, "_err"},   32'(err_len),       32'(0));
    check({tag, "_cnt"},   32'(words_written), 32'(0));
    check({tag, "_ready"}, 32'(s_ready),       32'(0));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // 4 back-to-back words 0x11..0x44, s_last on the 4th
    for (int i = 0; i < 4; i++) wdata[i] = DW'(8'h11 * (i + 1));
    run_load(4, 3, 0, 1'b0);

    // 3 words with s_valid toggling 1,0,1,0,1
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    run_load(3, 2, 1, 1'b0);

    // early s_last on the 2nd of 5
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    run_load(5, 1, 0, 1'b0);

    // num_words = DEPTH+7, no s_last: clamp to 8 writes
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    run_load(DEPTH + 7, 99, 0, 1'b0);

    // exact DEPTH words ending with s_last (address DEPTH-1 boundary)
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    run_load(DEPTH, DEPTH - 1, -1, 1'b0);

    // empty load
    run_load(0, 99, 0, 1'b0);

    // reset after 2 of 6 words
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = CW'(6);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    drive_word(wdata[0], 1'b0, 0, 1'b0);
    drive_word(wdata[1], 1'b0, 1, 1'b0);
    @(posedge clk); #1;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = wdata[2];
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("midrst_pending", 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
    run_load(2, 1, 0, 1'b0);

    // randomized loads, including ignored starts during LOAD
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom_range(0, 255));
      run_load($urandom_range(0, 12), $urandom_range(0, 10), -1, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
